// File: rtl/ipv4_tx.sv
// IPv4 transmit framer: prepends a 20-byte option-less header (length, rolling ID,
// checksum) to each transport packet, then passes the payload through unchanged.
module ipv4_tx #(
    parameter int          DATA_W   = 16,
    parameter int          LEN_W    = $clog2(DATA_W/8+1),
    parameter logic [31:0] SRC_ADDR = {8'd10, 8'd0, 8'd0, 8'd1},
    parameter logic [31:0] DST_ADDR = {8'd10, 8'd0, 8'd0, 8'd2},
    parameter logic [7:0]  PROTOCOL = 8'd17,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              term_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [15:0]       payload_len_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              start_o,
    output logic              term_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    input  logic              ready_i,
    output logic              cancel_o,
    output logic              len_err_o
);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, DROP} state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [15:0] id_q, id_hdr_q, tot_len_q, plen_q, csum_q;
    logic [16:0] cnt_q;
    logic        len_err_q;

    logic [31:0] sum0, sum1, sum2;
    logic [15:0] csum_d;
    logic [15:0] hdr_word;

    // One's-complement sum of all header words except the checksum slot itself.
    always_comb begin
        sum0 = 32'h4500 + 32'(tot_len_q) + 32'(id_hdr_q) + 32'h4000
             + 32'({TTL, PROTOCOL})
             + 32'(SRC_ADDR[31:16]) + 32'(SRC_ADDR[15:0])
             + 32'(DST_ADDR[31:16]) + 32'(DST_ADDR[15:0]);
        sum1   = {16'h0, sum0[15:0]} + {16'h0, sum0[31:16]};
        sum2   = {16'h0, sum1[15:0]} + {16'h0, sum1[31:16]};
        csum_d = ~sum2[15:0];
    end

    always_comb begin
        hdr_word = 16'h0;
        case (idx_q)
            4'd0:    hdr_word = 16'h4500;
            4'd1:    hdr_word = tot_len_q;
            4'd2:    hdr_word = id_hdr_q;
            4'd3:    hdr_word = 16'h4000;
            4'd4:    hdr_word = {TTL, PROTOCOL};
            4'd5:    hdr_word = csum_q;
            4'd6:    hdr_word = SRC_ADDR[31:16];
            4'd7:    hdr_word = SRC_ADDR[15:0];
            4'd8:    hdr_word = DST_ADDR[31:16];
            4'd9:    hdr_word = DST_ADDR[15:0];
            default: hdr_word = 16'h0;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        start_o = 1'b0;
        term_o  = 1'b0;
        data_o  = '0;
        len_o   = '0;
        case (state_q)
            HEAD: begin
                valid_o = 1'b1;
                start_o = (idx_q == 4'd0);
                len_o   = LEN_W'(2);
                // Wire order is big-endian, so the high byte of a word goes out first.
                data_o  = {hdr_word[7:0], hdr_word[15:8]};
            end
            DATA: begin
                ready_o = ready_i;
                valid_o = valid_i;
                term_o  = term_i;
                data_o  = data_i;
                len_o   = len_i;
            end
            DROP:    ready_o = 1'b1;
            default: ;
        endcase
    end

    assign cancel_o  = cancel_i & (state_q != IDLE);
    assign len_err_o = len_err_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            id_q      <= 16'h0;
            id_hdr_q  <= 16'h0;
            tot_len_q <= 16'h0;
            plen_q    <= 16'h0;
            csum_q    <= 16'h0;
            cnt_q     <= 17'h0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (cancel_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (valid_i && start_i) begin
                        if (payload_len_i > 16'd65515) begin
                            state_q   <= DROP;
                            len_err_q <= 1'b1;
                        end else begin
                            tot_len_q <= payload_len_i + 16'd20;
                            plen_q    <= payload_len_i;
                            id_hdr_q  <= id_q;
                            id_q      <= id_q + 16'd1;
                            idx_q     <= 4'd0;
                            cnt_q     <= 17'h0;
                            state_q   <= HEAD;
                        end
                    end
                    HEAD: begin
                        // Inputs to the sum are already latched, so beat 0 is a safe time.
                        if (idx_q == 4'd0) csum_q <= csum_d;
                        if (ready_i) begin
                            if (idx_q == 4'd9) state_q <= DATA;
                            else               idx_q   <= idx_q + 4'd1;
                        end
                    end
                    DATA: if (valid_i && ready_i) begin
                        cnt_q <= cnt_q + 17'(len_i);
                        if (term_i) begin
                            state_q <= IDLE;
                            if (cnt_q + 17'(len_i) != {1'b0, plen_q}) len_err_q <= 1'b1;
                        end
                    end
                    DROP: if (valid_i && term_i) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipv4_tx.sv
// Randomized bench for ipv4_tx: a byte-level packet model predicts every MAC beat and error pulse.
module tb_ipv4_tx;

    localparam logic [31:0] SRC = {8'd10, 8'd0, 8'd0, 8'd1};
    localparam logic [31:0] DST = {8'd10, 8'd0, 8'd0, 8'd2};
    localparam logic [7:0]  PRO = 8'd17;
    localparam logic [7:0]  TTLV = 8'd64;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cancel_i, valid_i, start_i, term_i, ready_i;
    logic [15:0] data_i, payload_len_i;
    logic [1:0]  len_i;
    logic        ready_o, valid_o, start_o, term_o, cancel_o, len_err_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] id_m = 16'h0;
    logic [15:0] hdr5;

    always #5 clk = ~clk;

    ipv4_tx dut (
        .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .valid_i(valid_i),
        .start_i(start_i), .term_i(term_i), .data_i(data_i), .len_i(len_i),
        .payload_len_i(payload_len_i), .ready_o(ready_o), .valid_o(valid_o),
        .start_o(start_o), .term_o(term_o), .data_o(data_o), .len_o(len_o),
        .ready_i(ready_i), .cancel_o(cancel_o), .len_err_o(len_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full packet from the transport side; expected MAC beats come from the header byte model.
    task automatic run_pkt(input int plen, input int nbytes, input bit bp);
        logic [7:0]  pb[$];
        logic [19:0] ib[$];
        logic [19:0] expq[$];
        logic [19:0] e;
        logic [7:0]  h[20];
        logic [15:0] tl, cs;
        logic [31:0] src, dst;
        int          s, nb, di, nerr, nextra, cyc, tail, obeat, lo_i;
        bit          drop, bad_rdy;

        drop = plen > 65515;
        for (int i = 0; i < nbytes; i++) pb.push_back(8'($urandom));
        nb = (nbytes + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            lo_i = 2 * k;
            if (lo_i + 1 < nbytes)
                ib.push_back({k == 0, k == nb - 1, 2'd2, pb[lo_i + 1], pb[lo_i]});
            else
                ib.push_back({k == 0, k == nb - 1, 2'd1, 8'($urandom), pb[lo_i]});
        end

        if (!drop) begin
            tl = 16'(plen + 20);
            src = SRC;
            dst = DST;
            h[0] = 8'h45;       h[1] = 8'h00;
            h[2] = tl[15:8];    h[3] = tl[7:0];
            h[4] = id_m[15:8];  h[5] = id_m[7:0];
            h[6] = 8'h40;       h[7] = 8'h00;
            h[8] = TTLV;        h[9] = PRO;
            h[10] = 8'h00;      h[11] = 8'h00;
            for (int b = 0; b < 4; b++) begin
                h[12 + b] = src[31 - 8*b -: 8];
                h[16 + b] = dst[31 - 8*b -: 8];
            end
            s = 0;
            for (int w = 0; w < 10; w++) s += {h[2*w], h[2*w + 1]};
            s = (s & 32'hFFFF) + (s >>> 16);
            s = (s & 32'hFFFF) + (s >>> 16);
            cs = ~s[15:0];
            h[10] = cs[15:8];
            h[11] = cs[7:0];
            for (int b = 0; b < 10; b++) expq.push_back({b == 0, 1'b0, 2'd2, h[2*b + 1], h[2*b]});
            foreach (ib[k]) expq.push_back({1'b0, ib[k][18:0]});
            id_m++;
        end

        payload_len_i = 16'(plen);
        di = 0; nerr = 0; nextra = 0; cyc = 0; tail = 0; obeat = 0; bad_rdy = 0;
        while (tail < 3 && cyc < 3000) begin
            @(negedge clk);
            if (di < nb) begin
                valid_i = bp ? ($urandom_range(3) != 0) : 1'b1;
                {start_i, term_i, len_i, data_i} = ib[di];
            end else begin
                valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; len_i = 2'd0; data_i = 16'h0;
            end
            ready_i = bp ? ($urandom_range(2) != 0) : 1'b1;
            #1;
            if (len_err_o) nerr++;
            if (!drop && obeat < 10 && ready_o) bad_rdy = 1;
            if (valid_o && ready_i) begin
                if (expq.size() == 0) nextra++;
                else begin
                    e = expq.pop_front();
                    chk($sformatf("beat%0d", obeat), {start_o, term_o, len_o, data_o}, e);
                end
                if (obeat == 5) hdr5 = data_o;
                obeat++;
            end
            if (valid_i && ready_o) di++;
            cyc++;
            if (di == nb && expq.size() == 0) tail++;
        end
        chk("pkt_done", 32'(tail), 32'd3);
        chk("in_beats", 32'(di), 32'(nb));
        chk("extra_beats", 32'(nextra), 32'd0);
        chk("len_err", 32'(nerr), (drop || nbytes != plen) ? 32'd1 : 32'd0);
        chk("hdr_ready_low", 32'(bad_rdy), 32'd0);
    endtask

    task automatic cancel_test();
        int obeat;
        obeat = 0;
        @(negedge clk);
        valid_i = 1'b1; start_i = 1'b1; term_i = 1'b0; len_i = 2'd2;
        data_i = 16'h1234; payload_len_i = 16'd6; ready_i = 1'b1;
        #1;
        for (int c = 0; c < 20 && obeat < 3; c++) begin
            if (valid_o && ready_i) obeat++;
            @(negedge clk);
            #1;
        end
        chk("cancel_reach", 32'(obeat), 32'd3);
        cancel_i = 1'b1; valid_i = 1'b0; start_i = 1'b0;
        #1;
        chk("cancel_beat3", {16'h0, data_o}, 32'h0040);
        chk("cancel_o_hi", 32'(cancel_o), 32'd1);
        id_m++;
        @(negedge clk);
        cancel_i = 1'b0;
        #1;
        chk("cancel_idle_valid", 32'(valid_o), 32'd0);
        chk("cancel_o_lo", 32'(cancel_o), 32'd0);
        @(negedge clk);
        #1;
        chk("cancel_no_err", 32'(len_err_o), 32'd0);
    endtask

    task automatic reset_test();
        @(negedge clk);
        valid_i = 1'b1; start_i = 1'b1; term_i = 1'b0; len_i = 2'd2;
        data_i = 16'hBEEF; payload_len_i = 16'd100; ready_i = 1'b1;
        repeat (13) @(negedge clk);
        #1;
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        chk("pre_rst_data", {16'h0, data_o}, 32'h0000BEEF);
        nreset = 1'b0;
        #1;
        chk("rst_outputs", {valid_o, start_o, term_o, ready_o, cancel_o, len_err_o, len_o, data_o},
            32'd0);
        valid_i = 1'b0; start_i = 1'b0;
        id_m = 16'h0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        nreset = 1'b0;
        cancel_i = 1'b0; valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0;
        data_i = 16'h0; len_i = 2'd0; payload_len_i = 16'h0; ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {valid_o, start_o, term_o, ready_o, cancel_o, len_err_o, len_o, data_o},
            32'd0);
        nreset = 1'b1;

        run_pkt(8, 8, 0);
        chk("basic_csum", {16'h0, hdr5}, 32'h0000CF26);
        run_pkt(8, 8, 0);
        chk("b2b_csum", {16'h0, hdr5}, 32'h0000CE26);
        run_pkt(7, 7, 0);
        for (int n = 0; n < 8; n++) begin
            int pl;
            pl = $urandom_range(1, 40);
            run_pkt(pl, pl, 1);
        end
        run_pkt(65516, 5, 1);
        run_pkt(8, 6, 0);
        run_pkt(65515, 4, 0);
        cancel_test();
        run_pkt(10, 10, 1);
        reset_test();
        run_pkt(4, 4, 0);
        run_pkt(9, 9, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
